// File: rtl/axis_conv_pkg.sv
// Shared helpers for the AXI4-Stream width converters.
//   - clog2 / idx_width : counter sizing
//   - widths_ok         : legality check for a wide/narrow width pair
//   - DEF_*_TDATA_WIDTH : default widths (512-bit core side, 64-bit sink side)
//   - state_e           : holding-register state (EMPTY / HOLD)
package axis_conv_pkg;

  localparam int unsigned DEF_S_TDATA_WIDTH = 512;
  localparam int unsigned DEF_M_TDATA_WIDTH = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Narrow side byte aligned, wide side an integer multiple of it, ratio >= 2.
  function automatic bit widths_ok(input int unsigned s_w, input int unsigned m_w);
    return (m_w >= 8) && (m_w % 8 == 0) && (s_w % m_w == 0) && (s_w / m_w >= 2);
  endfunction

endpackage

// File: rtl/axis_keep_last_lane.sv
// Finds the highest lane of a TKEEP vector that carries at least one valid byte.
//   keep_i        : byte qualifiers, NUM_LANES lanes of LANE_BYTES bits each
//   last_lane_o   : index of the highest lane with a nonzero slice (0 if none)
//   any_nonzero_o : 1 when any byte of keep_i is set
// Purely combinational.
module axis_keep_last_lane
  import axis_conv_pkg::*;
#(
  parameter  int unsigned NUM_LANES  = 8,
  parameter  int unsigned LANE_BYTES = 8,
  localparam int unsigned IDX_W      = idx_width(NUM_LANES)
) (
  input  logic [NUM_LANES*LANE_BYTES-1:0] keep_i,
  output logic [IDX_W-1:0]                last_lane_o,
  output logic                            any_nonzero_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    last_lane_o   = '0;
    any_nonzero_o = 1'b0;
    // Ascending scan: the last hit wins, giving the highest nonzero lane.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (|keep_i[i*LANE_BYTES +: LANE_BYTES]) begin
        last_lane_o   = IDX_W'(i);
        any_nonzero_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_width_downsizer.sv
// AXI4-Stream width downsizer: each wide input word is emitted as up to RATIO
// narrow beats, beat k = S_AXIS_TDATA[k*M_W +: M_W].
//   aclk / areset            : clock, asynchronous active-high reset
//   S_AXIS_T{DATA,KEEP,VALID,LAST,READY} : wide slave side
//   M_AXIS_T{DATA,KEEP,VALID,LAST,READY} : narrow master side
// On a TLAST word with TRIM_EN=1, trailing beats whose keep slice is all zero
// are dropped; an all-zero-keep TLAST word still yields one TKEEP=0 beat.
// A new word is accepted on the same edge the last beat of the held word
// leaves, so back-to-back words stream without bubbles.
module axis_width_downsizer
  import axis_conv_pkg::*;
#(
  parameter int unsigned S_TDATA_WIDTH = DEF_S_TDATA_WIDTH,
  parameter int unsigned M_TDATA_WIDTH = DEF_M_TDATA_WIDTH,
  parameter bit          TRIM_EN       = 1'b1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [S_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [S_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                       S_AXIS_TVALID,
  input  logic                       S_AXIS_TLAST,
  output logic                       S_AXIS_TREADY,
  output logic [M_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [M_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                       M_AXIS_TVALID,
  output logic                       M_AXIS_TLAST,
  input  logic                       M_AXIS_TREADY
);

  localparam int unsigned RATIO  = S_TDATA_WIDTH / M_TDATA_WIDTH;
  localparam int unsigned M_KEEP = M_TDATA_WIDTH / 8;
  localparam int unsigned IDX_W  = idx_width(RATIO);

  if (!widths_ok(S_TDATA_WIDTH, M_TDATA_WIDTH)) begin : g_bad_cfg
    $error("axis_width_downsizer: S_TDATA_WIDTH must be a multiple >=2 of a byte-aligned M_TDATA_WIDTH");
  end

  state_e                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           last_idx_q;
  logic [IDX_W-1:0]           last_idx_d;
  logic [S_TDATA_WIDTH-1:0]   data_q;
  logic [S_TDATA_WIDTH/8-1:0] keep_q;
  logic                       last_q;
  // Holds TREADY low during reset; set on the first edge after release.
  logic                       rdy_en_q;

  logic [IDX_W-1:0] hi_lane;
  logic             any_keep;
  logic             busy;
  logic             at_last;
  logic             m_hs;
  logic             s_hs;

  axis_keep_last_lane #(
    .NUM_LANES (RATIO),
    .LANE_BYTES(M_KEEP)
  ) u_last_lane (
    .keep_i       (S_AXIS_TKEEP),
    .last_lane_o  (hi_lane),
    .any_nonzero_o(any_keep)
  );

  assign busy    = (state_q == ST_HOLD);
  assign at_last = (idx_q == last_idx_q);
  assign m_hs    = busy && M_AXIS_TREADY;

  // Ready depends only on held state and M_AXIS_TREADY, never on S inputs.
  assign S_AXIS_TREADY = rdy_en_q && (!busy || (m_hs && at_last));
  assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    if (TRIM_EN && S_AXIS_TLAST) last_idx_d = any_keep ? hi_lane : '0;
    else                         last_idx_d = IDX_W'(RATIO - 1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      // NOTE: the wide data/keep regs are reset as well so TDATA/TKEEP read 0
      // during and right after reset instead of stale payload.
      state_q    <= ST_EMPTY;
      idx_q      <= '0;
      last_idx_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (s_hs) begin
        // Covers both the idle load and the zero-bubble reload on the final beat.
        data_q     <= S_AXIS_TDATA;
        keep_q     <= S_AXIS_TKEEP;
        last_q     <= S_AXIS_TLAST;
        last_idx_q <= last_idx_d;
        idx_q      <= '0;
        state_q    <= ST_HOLD;
      end else if (m_hs) begin
        if (at_last) state_q <= ST_EMPTY;
        else         idx_q   <= idx_q + IDX_W'(1);
      end
    end
  end

  // Output mux reads registers only.
  assign M_AXIS_TVALID = busy;
  assign M_AXIS_TDATA  = data_q[idx_q*M_TDATA_WIDTH +: M_TDATA_WIDTH];
  assign M_AXIS_TKEEP  = keep_q[idx_q*M_KEEP +: M_KEEP];
  assign M_AXIS_TLAST  = busy && last_q && at_last;

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed bench for axis_width_downsizer: 512->64 with and without trimming,
// and a 128->64 build. Inputs change and outputs are sampled on the falling edge.
module tb_axis_width_downsizer;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int checks = 0;
  int fails  = 0;

  // 512 -> 64, trimming on
  logic [511:0] s_tdata = '0;
  logic [63:0]  s_tkeep = '0;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tvalid, m_tlast;
  logic         m_tready = 1'b1;

  // 512 -> 64, trimming off (shares slave payload)
  logic         nt_s_tvalid = 1'b0, nt_s_tready;
  logic [63:0]  nt_m_tdata;
  logic [7:0]   nt_m_tkeep;
  logic         nt_m_tvalid, nt_m_tlast;

  // 128 -> 64
  logic [127:0] w_s_tdata = '0;
  logic [15:0]  w_s_tkeep = '0;
  logic         w_s_tvalid = 1'b0, w_s_tlast = 1'b0, w_s_tready;
  logic [63:0]  w_m_tdata;
  logic [7:0]   w_m_tkeep;
  logic         w_m_tvalid, w_m_tlast;

  axis_width_downsizer #(.S_TDATA_WIDTH(512), .M_TDATA_WIDTH(64), .TRIM_EN(1'b1)) dut (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready));

  axis_width_downsizer #(.S_TDATA_WIDTH(512), .M_TDATA_WIDTH(64), .TRIM_EN(1'b0)) dut_nt (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TVALID(nt_s_tvalid),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(nt_s_tready),
    .M_AXIS_TDATA(nt_m_tdata), .M_AXIS_TKEEP(nt_m_tkeep), .M_AXIS_TVALID(nt_m_tvalid),
    .M_AXIS_TLAST(nt_m_tlast), .M_AXIS_TREADY(m_tready));

  axis_width_downsizer #(.S_TDATA_WIDTH(128), .M_TDATA_WIDTH(64), .TRIM_EN(1'b1)) dut_w (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(w_s_tdata), .S_AXIS_TKEEP(w_s_tkeep), .S_AXIS_TVALID(w_s_tvalid),
    .S_AXIS_TLAST(w_s_tlast), .S_AXIS_TREADY(w_s_tready),
    .M_AXIS_TDATA(w_m_tdata), .M_AXIS_TKEEP(w_m_tkeep), .M_AXIS_TVALID(w_m_tvalid),
    .M_AXIS_TLAST(w_m_tlast), .M_AXIS_TREADY(m_tready));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wide word whose beat k holds base + k.
  function automatic logic [511:0] build(input logic [63:0] base);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
    return r;
  endfunction

  // Presents one word on the 512-bit DUT for a single cycle; returns at the
  // falling edge after the accept edge, where beat 0 must be visible.
  task automatic send_word(input logic [511:0] d, input logic [63:0] kp, input logic l);
    @(negedge aclk);
    s_tdata = d; s_tkeep = kp; s_tlast = l; s_tvalid = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
  endtask

  // Expects n beats on consecutive cycles (M_AXIS_TREADY high), then idle.
  task automatic expect_beats(input string t, input int n, input logic [63:0] base,
                              input logic [63:0] kp, input bit lst);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_valid%0d", t, k), m_tvalid, 1'b1);
      check($sformatf("%s_data%0d", t, k), m_tdata, base + 64'(k));
      check($sformatf("%s_keep%0d", t, k), m_tkeep, kp[k*8 +: 8]);
      check($sformatf("%s_last%0d", t, k), m_tlast, lst && (k == n - 1));
      @(negedge aclk);
    end
    check($sformatf("%s_idle", t), m_tvalid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit prev_hs;
    logic [63:0] keep4;

    // Reset state
    @(negedge aclk);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tdata", m_tdata, 64'h0);
    check("rst_m_tkeep", m_tkeep, 8'h0);
    @(negedge aclk);
    areset = 1'b0;
    check("rel_s_tready_pre", s_tready, 1'b0);
    @(negedge aclk);
    check("rel_s_tready_post", s_tready, 1'b1);

    // 1: single TLAST word, 8 beats, TLAST on beat 8
    send_word(build(64'h1), '1, 1'b1);
    expect_beats("t1", 8, 64'h1, '1, 1'b1);

    // 2: two back-to-back words, no gap, ready pulses on beats 8 and 16
    s_tdata = build(64'h10); s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge aclk);
    s_tdata = build(64'h20); s_tlast = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t2_valid%0d", k), m_tvalid, 1'b1);
      check($sformatf("t2_data%0d", k), m_tdata, (k < 8) ? 64'(16 + k) : 64'(32 + k - 8));
      check($sformatf("t2_last%0d", k), m_tlast, k == 15);
      check($sformatf("t2_sready%0d", k), s_tready, (k == 7) || (k == 15));
      if (k == 8) s_tvalid = 1'b0;
      @(negedge aclk);
    end
    check("t2_idle", m_tvalid, 1'b0);

    // 3: trimmed TLAST word -> 3 beats
    send_word(build(64'h30), 64'h0000_0000_00FF_FFFF, 1'b1);
    expect_beats("t3", 3, 64'h30, 64'h0000_0000_00FF_FFFF, 1'b1);

    // 3b: same word, trimming disabled -> 8 beats
    nt_s_tvalid = 1'b1;
    @(negedge aclk);
    nt_s_tvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3b_valid%0d", k), nt_m_tvalid, 1'b1);
      check($sformatf("t3b_data%0d", k), nt_m_tdata, 64'h30 + 64'(k));
      check($sformatf("t3b_keep%0d", k), nt_m_tkeep, (k < 3) ? 8'hFF : 8'h00);
      check($sformatf("t3b_last%0d", k), nt_m_tlast, k == 7);
      @(negedge aclk);
    end
    check("t3b_idle", nt_m_tvalid, 1'b0);

    // 4: random output stalls, non-TLAST word with zero keep slices kept
    keep4 = 64'h0000_00FF_FF00_FFFF;
    s_tdata = build(64'hA5A5_0000_0000_0000); s_tkeep = keep4; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
    cnt = 0;
    prev_hs = 1'b0;
    for (int c = 0; c < 64 && cnt < 8; c++) begin
      if (prev_hs) cnt++;
      if (cnt < 8) begin
        check($sformatf("t4_valid_c%0d", c), m_tvalid, 1'b1);
        check($sformatf("t4_data_c%0d", c), m_tdata, 64'hA5A5_0000_0000_0000 + 64'(cnt));
        check($sformatf("t4_keep_c%0d", c), m_tkeep, keep4[cnt*8 +: 8]);
        check($sformatf("t4_last_c%0d", c), m_tlast, 1'b0);
      end
      m_tready = 1'($urandom_range(0, 1));
      prev_hs = m_tvalid && m_tready;
      @(negedge aclk);
    end
    check("t4_beat_count", 32'(cnt), 32'd8);
    check("t4_idle", m_tvalid, 1'b0);
    m_tready = 1'b1;

    // 5: reset asserted while beat 3 is held
    send_word(build(64'h50), '1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5_data%0d", k), m_tdata, 64'h50 + 64'(k));
      @(negedge aclk);
    end
    check("t5_data3", m_tdata, 64'h53);
    m_tready = 1'b0;
    #1 areset = 1'b1;
    #1;
    check("t5_async_valid", m_tvalid, 1'b0);
    check("t5_async_data", m_tdata, 64'h0);
    check("t5_async_sready", s_tready, 1'b0);
    @(negedge aclk);
    areset = 1'b0;
    m_tready = 1'b1;
    @(negedge aclk);
    check("t5_no_resume", m_tvalid, 1'b0);
    check("t5_sready", s_tready, 1'b1);
    send_word(build(64'h60), 64'hFF, 1'b1);
    expect_beats("t5n", 1, 64'h60, 64'hFF, 1'b1);

    // 6a: all-zero keep TLAST word -> one TKEEP=0, TLAST=1 beat
    send_word(build(64'h70), 64'h0, 1'b1);
    expect_beats("t6a", 1, 64'h70, 64'h0, 1'b1);

    // 6b: 128->64 build, ratio 2, then all-zero keep TLAST word
    w_s_tdata = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    w_s_tkeep = 16'hFFFF; w_s_tlast = 1'b0; w_s_tvalid = 1'b1;
    @(negedge aclk);
    w_s_tvalid = 1'b0;
    check("t6b_data0", w_m_tdata, 64'hAAAA_AAAA_AAAA_AAAA);
    check("t6b_last0", w_m_tlast, 1'b0);
    @(negedge aclk);
    check("t6b_data1", w_m_tdata, 64'hBBBB_BBBB_BBBB_BBBB);
    check("t6b_keep1", w_m_tkeep, 8'hFF);
    check("t6b_last1", w_m_tlast, 1'b0);
    @(negedge aclk);
    check("t6b_idle", w_m_tvalid, 1'b0);
    w_s_tdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC};
    w_s_tkeep = 16'h0000; w_s_tlast = 1'b1; w_s_tvalid = 1'b1;
    @(negedge aclk);
    w_s_tvalid = 1'b0;
    check("t6b_z_valid", w_m_tvalid, 1'b1);
    check("t6b_z_data", w_m_tdata, 64'hCCCC_CCCC_CCCC_CCCC);
    check("t6b_z_keep", w_m_tkeep, 8'h00);
    check("t6b_z_last", w_m_tlast, 1'b1);
    @(negedge aclk);
    check("t6b_z_idle", w_m_tvalid, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
